// File: rtl/ctrl_mem_sequencer.sv
// Configuration sequencer: stores up to DEPTH config words and replays entries
// 0..num_cfg-1 for num_iter loops over an en/rdy transmit port.
module ctrl_mem_sequencer #(
  parameter int CFG_W  = 49,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH),
  parameter int ITER_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              recv_wr__en,
  input  logic [AW-1:0]     recv_wr__addr,
  input  logic [CFG_W-1:0]  recv_wr__msg,
  output logic              recv_wr__rdy,
  input  logic              start,
  input  logic [AW:0]       num_cfg,
  input  logic [ITER_W-1:0] num_iter,
  output logic              send_ctrl__en,
  output logic [CFG_W-1:0]  send_ctrl__msg,
  input  logic              send_ctrl__rdy,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [AW:0]       DEPTH_C  = DEPTH[AW:0];
  localparam logic [AW:0]       CFG_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0]     PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [ITER_W-1:0] ITER_ONE = {{(ITER_W-1){1'b0}}, 1'b1};

  logic [1:0]        state, state_nxt;
  logic [AW-1:0]     ptr, ptr_nxt;
  logic [ITER_W-1:0] iter, iter_nxt;
  logic [AW:0]       cfg_lat, cfg_lat_nxt;
  logic [ITER_W-1:0] iter_lat, iter_lat_nxt;

  logic [CFG_W-1:0]  mem [DEPTH];

  logic [AW:0] cfg_clamped;
  logic        last_ptr;
  logic        last_iter;
  logic        wr_fire;

  assign cfg_clamped = (num_cfg > DEPTH_C) ? DEPTH_C : num_cfg;
  assign last_ptr    = ({1'b0, ptr} == (cfg_lat - CFG_ONE));
  assign last_iter   = (iter == (iter_lat - ITER_ONE));
  assign wr_fire     = (state == IDLE) && recv_wr__en;

  // Handshake outputs are combinational so en can never run ahead of rdy.
  assign recv_wr__rdy   = (state == IDLE);
  assign busy           = (state == RUN);
  assign done           = (state == DONE);
  assign send_ctrl__en  = (state == RUN) && send_ctrl__rdy;
  assign send_ctrl__msg = mem[ptr];

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    iter_nxt     = iter;
    cfg_lat_nxt  = cfg_lat;
    iter_lat_nxt = iter_lat;
    case (state)
      IDLE: begin
        if (start) begin
          cfg_lat_nxt  = cfg_clamped;
          iter_lat_nxt = num_iter;
          ptr_nxt      = '0;
          iter_nxt     = '0;
          if ((cfg_clamped == '0) || (num_iter == '0)) begin
            state_nxt = DONE;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (send_ctrl__en) begin
          if (last_ptr) begin
            ptr_nxt  = '0;
            iter_nxt = iter + ITER_ONE;
            if (last_iter) begin
              state_nxt = DONE;
            end
          end else begin
            ptr_nxt = ptr + PTR_ONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= '0;
      iter     <= '0;
      cfg_lat  <= '0;
      iter_lat <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      iter     <= iter_nxt;
      cfg_lat  <= cfg_lat_nxt;
      iter_lat <= iter_lat_nxt;
    end
  end

  // NOTE: the config store is reset to zero so a replay before any write sends
  // known words; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_fire) begin
      mem[recv_wr__addr] <= recv_wr__msg;
    end
  end

endmodule

// File: tb/tb_ctrl_mem_sequencer.sv
// Directed bench for ctrl_mem_sequencer: a small memory/sequence model supplies
// every expected word, en, done and busy value.
module tb_ctrl_mem_sequencer;

  localparam int CFG_W  = 49;
  localparam int DEPTH  = 8;
  localparam int AW     = 3;
  localparam int ITER_W = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              recv_wr__en = 1'b0;
  logic [AW-1:0]     recv_wr__addr = '0;
  logic [CFG_W-1:0]  recv_wr__msg = '0;
  logic              recv_wr__rdy;
  logic              start = 1'b0;
  logic [AW:0]       num_cfg = '0;
  logic [ITER_W-1:0] num_iter = '0;
  logic              send_ctrl__en;
  logic [CFG_W-1:0]  send_ctrl__msg;
  logic              send_ctrl__rdy = 1'b1;
  logic              busy;
  logic              done;

  logic [CFG_W-1:0] model_mem [DEPTH];
  logic [CFG_W-1:0] exp_w [64];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ctrl_mem_sequencer #(
    .CFG_W (CFG_W),
    .DEPTH (DEPTH),
    .AW    (AW),
    .ITER_W(ITER_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .recv_wr__en   (recv_wr__en),
    .recv_wr__addr (recv_wr__addr),
    .recv_wr__msg  (recv_wr__msg),
    .recv_wr__rdy  (recv_wr__rdy),
    .start         (start),
    .num_cfg       (num_cfg),
    .num_iter      (num_iter),
    .send_ctrl__en (send_ctrl__en),
    .send_ctrl__msg(send_ctrl__msg),
    .send_ctrl__rdy(send_ctrl__rdy),
    .busy          (busy),
    .done          (done)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [CFG_W-1:0] data);
    recv_wr__en   = 1'b1;
    recv_wr__addr = addr;
    recv_wr__msg  = data;
    model_mem[addr] = data;
    cyc();
    recv_wr__en = 1'b0;
  endtask

  // mode 0: rdy always 1; mode 1: rdy pattern 1,0,0 repeating;
  // mode 2: rdy 1, with start and a write to addr 0 injected mid-run.
  task automatic run(input logic [AW:0] nc, input logic [ITER_W-1:0] ni, input int mode);
    int cl;
    int n_exp;
    int got;
    int k;
    logic finished;
    cl = (int'(nc) > DEPTH) ? DEPTH : int'(nc);
    n_exp = 0;
    for (int it = 0; it < int'(ni); it++) begin
      for (int p = 0; p < cl; p++) begin
        exp_w[n_exp] = model_mem[p];
        n_exp++;
      end
    end
    num_cfg  = nc;
    num_iter = ni;
    start    = 1'b1;
    cyc();
    start       = 1'b0;
    recv_wr__en = 1'b0;
    got = 0;
    k = 0;
    finished = 1'b0;
    while (!finished && k < 300) begin
      if (got == n_exp) begin
        #1;
        check("done_pulse", done, 1'b1);
        check("en_in_done", send_ctrl__en, 1'b0);
        check("busy_in_done", busy, 1'b0);
        if (mode == 0) check("done_cycle", k, n_exp);
        cyc();
        #1;
        check("done_cleared", done, 1'b0);
        check("idle_wr_rdy", recv_wr__rdy, 1'b1);
        finished = 1'b1;
      end else begin
        send_ctrl__rdy = (mode == 1) ? (k % 3 == 0) : 1'b1;
        if (mode == 2 && k == 2) begin
          start         = 1'b1;
          recv_wr__en   = 1'b1;
          recv_wr__addr = '0;
          recv_wr__msg  = 49'h1_DEAD_BEEF_0BAD;
        end else begin
          start       = 1'b0;
          recv_wr__en = 1'b0;
        end
        #1;
        check("busy_run", busy, 1'b1);
        check("wr_rdy_run", recv_wr__rdy, 1'b0);
        check("done_run", done, 1'b0);
        check("en_follows_rdy", send_ctrl__en, send_ctrl__rdy);
        check("msg", send_ctrl__msg, exp_w[got]);
        if (send_ctrl__rdy) got++;
        cyc();
        k++;
      end
    end
    start          = 1'b0;
    recv_wr__en    = 1'b0;
    send_ctrl__rdy = 1'b1;
    check("run_finished", finished, 1'b1);
    cyc();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

    // Reset held three cycles with rdy high
    repeat (3) cyc();
    check("rst_wr_rdy", recv_wr__rdy, 1'b1);
    check("rst_en", send_ctrl__en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_msg", send_ctrl__msg, '0);
    cyc();
    reset = 1'b1;
    cyc();

    // Basic replay
    wr(3'd0, 49'h0_0000_0000_00A0);
    wr(3'd1, 49'h1_1111_1111_11A1);
    wr(3'd2, 49'h0_2222_2222_22A2);
    run(4'd3, 16'd2, 0);

    // Backpressure
    run(4'd3, 16'd2, 1);

    // Degenerate lengths and clamp
    run(4'd0, 16'd5, 0);
    run(4'd3, 16'd0, 0);
    wr(3'd3, 49'h1_3333_0000_33A3);
    wr(3'd4, 49'h0_4444_0000_44A4);
    wr(3'd5, 49'h1_5555_0000_55A5);
    wr(3'd6, 49'h0_6666_0000_66A6);
    wr(3'd7, 49'h1_7777_0000_77A7);
    run(4'd12, 16'd1, 0);

    // Full-depth wrap with injected start/write that must be ignored
    run(4'd8, 16'd3, 2);
    run(4'd1, 16'd1, 0);

    // Same-cycle write and start
    recv_wr__en   = 1'b1;
    recv_wr__addr = 3'd0;
    recv_wr__msg  = 49'h0_BBBB_CAFE_000B;
    model_mem[0]  = 49'h0_BBBB_CAFE_000B;
    run(4'd2, 16'd1, 0);

    // Reset asserted mid-run
    num_cfg  = 4'd8;
    num_iter = 16'd3;
    start    = 1'b1;
    cyc();
    start = 1'b0;
    repeat (2) cyc();
    check("mid_run_en", send_ctrl__en, 1'b1);
    reset = 1'b0;
    #1;
    check("abort_en", send_ctrl__en, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_wr_rdy", recv_wr__rdy, 1'b1);
    check("abort_msg_cleared", send_ctrl__msg, '0);
    cyc();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("no_done_after_abort", done, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
